// File: rtl/serial_add_arb_pkg.sv
// Shared types and constants for the bit-serial adder arbiter.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_arb_if.sv
// Request/response bundle for serial_add_arb; SERIAL_ADD_SUB_EN adds the per-request subtract flags.
interface serial_add_arb_if
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
`ifdef SERIAL_ADD_SUB_EN
  logic             req0_sub;
  logic             req1_sub;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_carry;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output req0_sub, req1_sub,
`endif
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  req0_sub, req1_sub,
`endif
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

endinterface

// File: rtl/serial_add_arb_bit.sv
// One-bit full adder cell built from two half-adder stages.
module serial_add_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic hs1, hc1, hc2;

  assign hs1 = a_i ^ b_i;
  assign hc1 = a_i & b_i;
  assign s_o = hs1 ^ c_i;
  assign hc2 = hs1 & c_i;
  assign c_o = hc1 | hc2;

endmodule

// File: rtl/serial_add_arb.sv
// Round-robin arbiter feeding two requesters into one shared bit-serial adder cell.
// Optional SERIAL_ADD_SUB_EN: per-request subtract (b inverted, carry-in 1).
module serial_add_arb
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_arb_if.slave bus
);
  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, rsp_carry_q, rsp_id_q, last_q, sub_q;
  logic             grant0, grant1, accept, sub_sel;
  logic             s_bit, c_bit, b_bit;

  // last_q holds the index granted last; the other requester wins a tie
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = grant0 ? bus.req0_sub : bus.req1_sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign bus.req0_ready = (state_q == IDLE) & grant0;
  assign bus.req1_ready = (state_q == IDLE) & grant1;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_carry  = rsp_carry_q;

  assign b_bit = b_q[0] ^ sub_q;

  serial_add_bit u_cell (
    .a_i (a_q[0]),
    .b_i (b_bit),
    .c_i (carry_q),
    .s_o (s_bit),
    .c_o (c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (grant0 | grant1) begin
        accept  = 1'b1;
        state_d = ADD;
      end
      ADD:  if (cnt_q == CNT_LAST) state_d = DONE;
      DONE: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      sub_q       <= 1'b0;
      last_q      <= 1'b1;
    end else if (accept) begin
      a_q      <= grant0 ? bus.req0_a : bus.req1_a;
      b_q      <= grant0 ? bus.req0_b : bus.req1_b;
      sub_q    <= sub_sel;
      carry_q  <= sub_sel;
      cnt_q    <= '0;
      rsp_id_q <= grant1;
      last_q   <= grant1;
    end else if (state_q == ADD) begin
      // sum fills from the MSB so the first (LSB) result bit lands in bit 0 after WIDTH shifts
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {s_bit, sum_q[WIDTH-1:1]};
      carry_q <= c_bit;
      cnt_q   <= cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) rsp_carry_q <= c_bit;
    end
  end

endmodule

// File: tb/tb_serial_add_arb.sv
// Scoreboard bench for serial_add_arb; covers the subtract path when SERIAL_ADD_SUB_EN is defined.
`timescale 1ns/1ps
module tb_serial_add_arb;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_arb_if #(.WIDTH(W)) bus ();
  serial_add_arb #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_rsp = 0;
  exp_t sb[$];
  logic sub0_v = 1'b0;
  logic sub1_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub);
    logic [W:0] t;
    exp_t e;
    if (sub) t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     t = {1'b0, a} + {1'b0, b};
    e.id = id; e.sum = t[W-1:0]; e.carry = t[W];
    return e;
  endfunction

  // scoreboard: push on request handshake, pop and compare on response handshake
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (!rst_n) sb.delete();
    else begin
      if (bus.req0_valid && bus.req0_ready) sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, sub0_v));
      if (bus.req1_valid && bus.req1_ready) sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, sub1_v));
      if (bus.req0_ready || bus.req1_ready) begin
        checks++;
        if ((bus.req0_ready && bus.req1_ready) || bus.rsp_valid) begin
          errors++;
          $display("FAIL ready_excl: ready0=%0b ready1=%0b rsp_valid=%0b, required at most one ready and only in IDLE",
                   bus.req0_ready, bus.req1_ready, bus.rsp_valid);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_spurious: response id=%0d sum=%h with no outstanding request", bus.rsp_id, bus.rsp_sum);
        end else begin
          e = sb.pop_front();
          if (bus.rsp_id !== e.id || bus.rsp_sum !== e.sum || bus.rsp_carry !== e.carry) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d sum=%h carry=%0b, required id=%0d sum=%h carry=%0b",
                     bus.rsp_id, bus.rsp_sum, bus.rsp_carry, e.id, e.sum, e.carry);
          end
        end
      end
    end
  end

  task automatic drive(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; sub0_v = sub;
`ifdef SERIAL_ADD_SUB_EN
      bus.req0_sub = sub;
`endif
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; sub1_v = sub;
`ifdef SERIAL_ADD_SUB_EN
      bus.req1_sub = sub;
`endif
    end
  endtask

  // returns at the negedge after the accepting edge with valid dropped
  task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      output int acc_cyc);
    bit got = 0;
    @(negedge clk);
    drive(id, 1'b1, a, b, sub);
    for (int t = 0; t < 60 && !got; t++) begin
      #1;
      got = (id == 0) ? bus.req0_ready : bus.req1_ready;
      if (!got) @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: requester %0d never saw ready", id);
    end
    @(negedge clk);
    acc_cyc = cyc;
    drive(id, 1'b0, a, b, sub);
  endtask

  task automatic wait_rsp(output int at_cyc);
    int t = 0;
    while (!bus.rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    at_cyc = cyc;
    if (!bus.rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid=0 after %0d cycles, required 1", t);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_carry !== 1'b0 || bus.rsp_id !== 1'b0 ||
        bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: valid=%0b sum=%h carry=%0b id=%0b r0=%0b r1=%0b, required all 0",
               bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_id, bus.req0_ready, bus.req1_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add();
    int acc, t;
    send(0, 8'h5A, 8'h3C, 1'b0, acc);
    wait_rsp(t);
    checks++;
    if (t - acc != W) begin errors++; $display("FAIL latency: got %0d, required %0d", t - acc, W); end
    checks++;
    if (bus.rsp_id !== 1'b0 || bus.rsp_sum !== 8'h96 || bus.rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL basic_add: id=%0d sum=%h carry=%0b, required id=0 sum=96 carry=0",
               bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
    end
    @(posedge clk);
  endtask

  task automatic test_carry_out();
    int acc, t;
    send(1, 8'hFF, 8'h01, 1'b0, acc);
    wait_rsp(t);
    checks++;
    if (bus.rsp_id !== 1'b1 || bus.rsp_sum !== 8'h00 || bus.rsp_carry !== 1'b1) begin
      errors++;
      $display("FAIL carry_out: id=%0d sum=%h carry=%0b, required id=1 sum=00 carry=1",
               bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n1 = 0, exp_g = 0, last_acc = -1, g, r_base;
    do_reset();
    r_base = n_rsp;
    drive(0, 1'b1, 8'd3, 8'd200, 1'b0);
    drive(1, 1'b1, 8'd8, 8'd213, 1'b0);
    for (int c = 0; c < 400 && (n0 < 4 || n1 < 4); c++) begin
      #1;
      g = -1;
      if (bus.req0_valid && bus.req0_ready) g = 0;
      else if (bus.req1_valid && bus.req1_ready) g = 1;
      if (g >= 0) begin
        checks++;
        if (g != exp_g) begin errors++; $display("FAIL grant_order: got %0d, required %0d", g, exp_g); end
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != W + 2) begin
            errors++;
            $display("FAIL accept_spacing: got %0d, required %0d", cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        exp_g = 1 - exp_g;
        if (g == 0) n0++; else n1++;
      end
      @(negedge clk);
      if (g == 0) drive(0, n0 < 4, 8'(n0 * 37 + 3), 8'(n0 * 91 + 200), 1'b0);
      if (g == 1) drive(1, n1 < 4, 8'(n1 * 37 + 8), 8'(n1 * 91 + 213), 1'b0);
    end
    checks++;
    if (n0 != 4 || n1 != 4) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d/%0d, required 4/4", n0, n1);
    end
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    @(posedge clk); #1;
    checks++;
    if (n_rsp - r_base != 8) begin
      errors++;
      $display("FAIL b2b_rsp_count: got %0d, required 8", n_rsp - r_base);
    end
  endtask

  task automatic test_backpressure();
    int acc, t;
    bus.rsp_ready = 1'b0;
    send(0, 8'hC3, 8'h4D, 1'b0, acc);
    drive(1, 1'b1, 8'h07, 8'h09, 1'b0);
    wait_rsp(t);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_sum !== 8'h10 ||
          bus.rsp_carry !== 1'b1 || bus.req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%0b id=%0d sum=%h carry=%0b r1=%0b, required 1/0/10/1/0",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.req1_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL early_accept: r1=%0b, required 0", bus.req1_ready); end
    @(negedge clk); #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL accept_after_hs: r1=%0b, required 1", bus.req1_ready); end
    @(negedge clk);
    drive(1, 1'b0, 8'h07, 8'h09, 1'b0);
    wait_rsp(t);
    checks++;
    if (bus.rsp_id !== 1'b1 || bus.rsp_sum !== 8'h10 || bus.rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL bp_second: id=%0d sum=%h carry=%0b, required id=1 sum=10 carry=0",
               bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_abort();
    int acc, t;
    bit seen = 0;
    send(1, 8'h12, 8'h34, 1'b0, acc);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== '0 || bus.rsp_carry !== 1'b0 || bus.rsp_id !== 1'b0 ||
        bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_vals: valid=%0b sum=%h carry=%0b id=%0b r0=%0b r1=%0b, required all 0",
               bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_id, bus.req0_ready, bus.req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_no_rsp: rsp_valid=1, required 0 after abort"); end
    send(0, 8'h81, 8'h81, 1'b0, acc);
    wait_rsp(t);
    checks++;
    if (bus.rsp_id !== 1'b0 || bus.rsp_sum !== 8'h02 || bus.rsp_carry !== 1'b1) begin
      errors++;
      $display("FAIL post_abort: id=%0d sum=%h carry=%0b, required id=0 sum=02 carry=1",
               bus.rsp_id, bus.rsp_sum, bus.rsp_carry);
    end
    @(posedge clk);
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub();
    int acc, t;
    send(0, 8'h10, 8'h01, 1'b1, acc);
    wait_rsp(t);
    checks++;
    if (bus.rsp_sum !== 8'h0F || bus.rsp_carry !== 1'b1) begin
      errors++;
      $display("FAIL sub_no_borrow: sum=%h carry=%0b, required 0f/1", bus.rsp_sum, bus.rsp_carry);
    end
    @(posedge clk);
    send(1, 8'h01, 8'h02, 1'b1, acc);
    wait_rsp(t);
    checks++;
    if (bus.rsp_sum !== 8'hFF || bus.rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: sum=%h carry=%0b, required ff/0", bus.rsp_sum, bus.rsp_carry);
    end
    @(posedge clk);
  endtask
`endif

  initial begin
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    bus.rsp_ready = 1'b1;
    test_reset();
    test_basic_add();
    test_carry_out();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d pending, required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_arb.md
# serial_add_arb

Bit-serial adder controller that shares a single one-bit adder cell between two requesters. Each request carries two WIDTH-bit operands; the block arbitrates round-robin, accepts one request, shifts the operands through the adder cell LSB-first over WIDTH cycles, and returns sum and carry-out on a valid/ready response port. It sits between operand producers and the arithmetic datapath, replacing a parallel adder where area matters more than throughput.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has operands.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_ready  out  1  requester 0 accepted this cycle when high with req0_valid.
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  index of the requester that owns the result.
- rsp_sum  out  WIDTH  sum, modulo 2^WIDTH.
- rsp_carry  out  1  carry-out of bit WIDTH-1.

## Operation
- States: IDLE, ADD, DONE.
- IDLE: reqN_ready = (state==IDLE) & grantN, combinational. Grant: only one valid, grant it; both valid, grant the one not granted last. On accept, latch a/b into shift registers, carry=0, bit counter=0, latch rsp_id, update the last-grant pointer, go to ADD.
- Last-grant pointer resets to 1, so requester 0 wins the first contention. Pointer changes only on accept.
- ADD: each cycle the cell computes s = a[0]^b[0]^c, c' = majority(a[0],b[0],c). Operands shift right by one; s enters the sum register MSB and the sum register shifts right. Counter increments. When counter == WIDTH-1, the next edge goes to DONE, with the final carry stored in rsp_carry.
- DONE: rsp_valid=1, rsp_sum/rsp_carry/rsp_id stable. On rsp_valid & rsp_ready, go to IDLE. No request is accepted in ADD or DONE.
- Reset values: state IDLE, rsp_valid 0, rsp_sum 0, rsp_carry 0, rsp_id 0, req0_ready 0, req1_ready 0. Pointer is 1.
- Reset asserted mid-ADD or in DONE aborts the operation. No response is produced for the aborted request.
- Requesters may drop valid in any cycle when ready is low. Operand changes after accept have no effect.

## Timing
- Accepting edge E0. rsp_valid rises on edge E0+WIDTH, which is WIDTH cycles of latency.
- With rsp_ready held high, the earliest next accept is on edge E0+WIDTH+2. Throughput is 1 result per WIDTH+2 cycles.
- rsp_valid stays high until the handshake and is never withdrawn except by reset.

## Configuration
- SERIAL_ADD_SUB_EN defined: adds ports req0_sub and req1_sub (in, 1), latched on accept.
  - When sub=1, the b operand enters the cell inverted and the initial carry is 1. The result is a-b mod 2^WIDTH.
  - rsp_carry=1 means no borrow.
- SERIAL_ADD_SUB_EN undefined: the sub ports do not exist and the block is add-only, with initial carry 0.

## Structure
- Package serial_add_pkg holds:
  - the state enum (IDLE/ADD/DONE);
  - the default WIDTH constant;
  - the counter-width function ($clog2(WIDTH)).
- Sub-module serial_add_bit is the combinational one-bit full adder. It is built from two half-adder stages plus an OR for the carry and is instantiated once.

## Test plan
- WIDTH=8, req0 a=0x5A b=0x3C -> rsp_valid exactly 8 cycles after accept, rsp_id=0, sum=0x96, carry=0.
- req1 a=0xFF b=0x01 -> sum=0x00, carry=1, rsp_id=1.
- Both valid from reset, 4 back-to-back requests each -> grants in the order 0,1,0,1. No request is lost or duplicated, and neither ready is high outside IDLE.
- rsp_ready low for 5 cycles in DONE -> rsp_valid, sum, carry and id held stable and no new accept. Accept occurs 1 cycle after the handshake.
- rst_n pulsed low at the 4th ADD cycle -> all outputs go to reset values immediately. No response appears, and the next request completes correctly.
- SERIAL_ADD_SUB_EN: a=0x10 b=0x01 sub=1 -> sum=0x0F, carry=1. a=0x01 b=0x02 sub=1 -> sum=0xFF, carry=0.
